ahb_bus_arbiter: RTL and testbench

- Shares one AHB bus between up to NumManagers managers, for example the Renode bus controller and the DMA master port, using the AHB2 HBUSREQ/HGRANT handshake.
- Drives the registered one-hot HGRANT and the HMASTER / HMASTER_DATA selects for the external address-phase and write-data multiplexers.
- Uses round-robin fairness with a bounded hold time.
- Optionally protects fixed-length bursts from being split.

---
 rtl/ahb_bus_arbiter.sv | 274 +++++++++++++++++++++++++++
 tb/tb_ahb_bus_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_bus_arbiter
//
// Shares one AHB bus between NumManagers managers using the AHB2
// HBUSREQ/HGRANT handshake. Grants are registered and one-hot. Arbitration
// is round-robin with a bounded hold time. HMASTER and HMASTER_DATA are
// provided as selects for the external address-phase and write-data muxes.
//
// Optional feature (compile-time macro AHB_ARBITER_BURST_HOLD_EN):
//   When defined, a BURST state freezes HGRANT for the length of a
//   fixed-length burst (WRAP4/INCR4/WRAP8/INCR8/WRAP16/INCR16).
//   When undefined, the arbiter always re-arbitrates on accepted transfers.
//
// Parameters:
//   NumManagers    number of managers (2..8)
//   DefaultManager manager granted when nobody requests and after reset
//   MaxHold        accepted transfers an owner may keep the bus while
//                  others request (1..255)
//   IdWidth        width of manager index (derived)
//
// Ports:
//   HCLK          bus clock, all logic on the rising edge
//   HRESET        synchronous active-high reset
//   HBUSREQ       per-manager bus request
//   HGRANT        registered one-hot grant
//   HMASTER       owner of the current address phase
//   HMASTER_DATA  owner of the current data phase
//   HTRANS        muxed transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   HBURST        muxed burst type
//   HREADY        bus ready
// ---------------------------------------------------------------------------
module ahb_bus_arbiter #(
  parameter int unsigned NumManagers    = 2,
  parameter int unsigned DefaultManager = 0,
  parameter int unsigned MaxHold        = 16,
  parameter int unsigned IdWidth        = (NumManagers > 1) ? $clog2(NumManagers) : 1
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NumManagers-1:0] HBUSREQ,
  output logic [NumManagers-1:0] HGRANT,
  output logic [IdWidth-1:0]     HMASTER,
  output logic [IdWidth-1:0]     HMASTER_DATA,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY
);

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic [IdWidth-1:0]     DefaultIdx   = IdWidth'(DefaultManager);
  localparam logic [NumManagers-1:0] DefaultGrant = NumManagers'(1) << DefaultManager;
  localparam logic [7:0]             HoldLimit    = 8'(MaxHold);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [NumManagers-1:0] grant_q, grant_d;
  logic [IdWidth-1:0]     hmaster_q, hmaster_d;
  logic [IdWidth-1:0]     hmaster_data_q, hmaster_data_d;
  logic [7:0]             hold_q, hold_d;

  // Arbitration enable: high on edges where the grant may move.
  logic                   arb_en;

  // -------------------------------------------------------------------------
  // Current grantee and round-robin search
  // -------------------------------------------------------------------------
  logic [IdWidth-1:0]     owner_idx;
  logic                   owner_req;
  logic                   others_req;
  logic                   any_req;
  logic                   rr_found;
  logic [IdWidth-1:0]     rr_idx;
  logic [IdWidth-1:0]     next_idx;
  logic [NumManagers-1:0] grant_next;

  always_comb begin
    owner_idx = '0;
    for (int unsigned i = 0; i < NumManagers; i++) begin
      if (grant_q[i]) owner_idx = IdWidth'(i);
    end
  end

  assign owner_req  = |(HBUSREQ & grant_q);
  assign others_req = |(HBUSREQ & ~grant_q);
  assign any_req    = |HBUSREQ;

  // Rotating priority from owner+1 without a modulo: first look above the
  // owner in ascending order, then wrap around and look below it.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = owner_idx;
    for (int unsigned i = 0; i < NumManagers; i++) begin
      if (!rr_found && HBUSREQ[i] && (IdWidth'(i) > owner_idx)) begin
        rr_found = 1'b1;
        rr_idx   = IdWidth'(i);
      end
    end
    for (int unsigned i = 0; i < NumManagers; i++) begin
      if (!rr_found && HBUSREQ[i] && (IdWidth'(i) < owner_idx)) begin
        rr_found = 1'b1;
        rr_idx   = IdWidth'(i);
      end
    end
  end

  always_comb begin
    next_idx = owner_idx;
    if (!any_req) begin
      next_idx = DefaultIdx;
    end else if (owner_req && ((hold_q < HoldLimit) || !others_req)) begin
      next_idx = owner_idx;
    end else if (rr_found) begin
      next_idx = rr_idx;
    end
  end

  always_comb begin
    grant_next = '0;
    for (int unsigned i = 0; i < NumManagers; i++) begin
      grant_next[i] = (IdWidth'(i) == next_idx);
    end
  end

  // -------------------------------------------------------------------------
  // Burst-hold FSM (optional)
  // -------------------------------------------------------------------------
`ifdef AHB_ARBITER_BURST_HOLD_EN
  typedef enum logic {
    ST_ARB,
    ST_BURST
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] beat_q, beat_d;
  logic       fixed_burst;
  logic [3:0] beats_m2;

  always_comb begin
    beats_m2 = '0;
    case (HBURST)
      3'd2, 3'd3: beats_m2 = 4'd2;   // WRAP4 / INCR4
      3'd4, 3'd5: beats_m2 = 4'd6;   // WRAP8 / INCR8
      3'd6, 3'd7: beats_m2 = 4'd14;  // WRAP16 / INCR16
      default:    beats_m2 = '0;
    endcase
  end

  assign fixed_burst = (HTRANS == HTRANS_NONSEQ) && (HBURST >= 3'd2);

  // Leaving BURST re-arbitrates on the same edge, so the grant can move on
  // the last beat's address (or on an early-terminating IDLE/NONSEQ).
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    arb_en  = 1'b0;
    if (HREADY) begin
      case (state_q)
        ST_ARB: begin
          arb_en = 1'b1;
          if (fixed_burst) begin
            state_d = ST_BURST;
            beat_d  = beats_m2;
          end
        end
        ST_BURST: begin
          case (HTRANS)
            HTRANS_SEQ: begin
              if (beat_q == '0) begin
                state_d = ST_ARB;
                arb_en  = 1'b1;
              end else begin
                beat_d = beat_q - 4'd1;
              end
            end
            HTRANS_BUSY: begin
              beat_d = beat_q;
            end
            default: begin
              state_d = ST_ARB;
              arb_en  = 1'b1;
              if (fixed_burst) begin
                state_d = ST_BURST;
                beat_d  = beats_m2;
              end
            end
          endcase
        end
        default: begin
          state_d = ST_ARB;
        end
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_ARB;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end
`else
  // Without burst protection the FSM never leaves ARB.
  logic unused_hburst;

  assign unused_hburst = ^HBURST;

  always_comb begin
    arb_en = HREADY;
  end
`endif

  // -------------------------------------------------------------------------
  // Grant, hold counter and ownership pipeline
  // -------------------------------------------------------------------------
  logic xfer_by_grantee;

  assign xfer_by_grantee = HREADY &&
                           ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ)) &&
                           (hmaster_q == owner_idx);

  always_comb begin
    grant_d = grant_q;
    if (arb_en) begin
      grant_d = grant_next;
    end
  end

  always_comb begin
    hold_d = hold_q;
    if (grant_d != grant_q) begin
      hold_d = '0;
    end else if (xfer_by_grantee && (hold_q < HoldLimit)) begin
      hold_d = hold_q + 8'd1;
    end
  end

  always_comb begin
    hmaster_d      = hmaster_q;
    hmaster_data_d = hmaster_data_q;
    if (HREADY) begin
      hmaster_d      = owner_idx;
      hmaster_data_d = hmaster_q;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      grant_q        <= DefaultGrant;
      hmaster_q      <= DefaultIdx;
      hmaster_data_q <= DefaultIdx;
      hold_q         <= '0;
    end else begin
      grant_q        <= grant_d;
      hmaster_q      <= hmaster_d;
      hmaster_data_q <= hmaster_data_d;
      hold_q         <= hold_d;
    end
  end

  assign HGRANT       = grant_q;
  assign HMASTER      = hmaster_q;
  assign HMASTER_DATA = hmaster_data_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
module tb_ahb_bus_arbiter;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_NONSEQ = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;
  localparam logic [2:0] B_SINGLE = 3'd0;
  localparam logic [2:0] B_INCR8  = 3'd5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Two-manager instance, MaxHold = 1
  logic       rst2;
  logic [1:0] req2;
  logic [1:0] trans2;
  logic [2:0] burst2;
  logic       ready2;
  logic [1:0] grant2;
  logic [0:0] hm2;
  logic [0:0] hmd2;

  // Four-manager instance, MaxHold = 2
  logic       rst4;
  logic [3:0] req4;
  logic [1:0] trans4;
  logic [2:0] burst4;
  logic       ready4;
  logic [3:0] grant4;
  logic [1:0] hm4;
  logic [1:0] hmd4;

  ahb_bus_arbiter #(
    .NumManagers   (2),
    .DefaultManager(0),
    .MaxHold       (1)
  ) u_dut2 (
    .HCLK        (clk),
    .HRESET      (rst2),
    .HBUSREQ     (req2),
    .HGRANT      (grant2),
    .HMASTER     (hm2),
    .HMASTER_DATA(hmd2),
    .HTRANS      (trans2),
    .HBURST      (burst2),
    .HREADY      (ready2)
  );

  ahb_bus_arbiter #(
    .NumManagers   (4),
    .DefaultManager(0),
    .MaxHold       (2)
  ) u_dut4 (
    .HCLK        (clk),
    .HRESET      (rst4),
    .HBUSREQ     (req4),
    .HGRANT      (grant4),
    .HMASTER     (hm4),
    .HMASTER_DATA(hmd4),
    .HTRANS      (trans4),
    .HBURST      (burst4),
    .HREADY      (ready4)
  );

  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected HGRANT after each beat edge of an INCR8 by mgr0 (mgr1 requesting),
  // and after NONSEQ, SEQ, SEQ, IDLE for the early-terminated variant.
  logic [1:0] exp_full  [1:8];
  logic [1:0] exp_early [1:4];
  // Expected 4-manager HGRANT after each continuous-NONSEQ edge.
  logic [3:0] exp_rr    [1:11];

  initial begin
`ifdef AHB_ARBITER_BURST_HOLD_EN
    exp_full  = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    exp_early = '{2'b01, 2'b01, 2'b01, 2'b10};
`else
    exp_full  = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};
    exp_early = '{2'b01, 2'b10, 2'b10, 2'b10};
`endif
    exp_rr = '{4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
               4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0001};

    rst2 = 1'b1; req2 = 2'b10; trans2 = T_IDLE; burst2 = B_SINGLE; ready2 = 1'b1;
    rst4 = 1'b1; req4 = 4'b0010; trans4 = T_IDLE; burst4 = B_SINGLE; ready4 = 1'b1;

    // Reset: default grant even though mgr1 requests, then handover.
    step();
    check("rst_grant", 32'(grant2), 32'h1);
    check("rst_hmaster", 32'(hm2), 32'h0);
    check("rst_hmaster_data", 32'(hmd2), 32'h0);
    rst2 = 1'b0;
    step();
    check("rst_release_grant", 32'(grant2), 32'h2);

    // Handover latency from an idle bus.
    rst2 = 1'b1; req2 = 2'b00;
    step();
    rst2 = 1'b0;
    repeat (4) step();
    check("ho_idle_grant", 32'(grant2), 32'h1);
    req2 = 2'b10;
    step();
    check("ho_grant", 32'(grant2), 32'h2);
    check("ho_hmaster_early", 32'(hm2), 32'h0);
    step();
    check("ho_hmaster", 32'(hm2), 32'h1);
    check("ho_hmaster_data_early", 32'(hmd2), 32'h0);
    step();
    check("ho_hmaster_data", 32'(hmd2), 32'h1);

    // Wait states freeze the grant even with the hold count exhausted.
    rst2 = 1'b1; req2 = 2'b01; trans2 = T_IDLE;
    step();
    rst2 = 1'b0;
    trans2 = T_NONSEQ; burst2 = B_SINGLE;
    step();
    check("ws_after_xfer", 32'(grant2), 32'h1);
    trans2 = T_IDLE; req2 = 2'b11; ready2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ws_frozen", 32'(grant2), 32'h1);
    end
    ready2 = 1'b1;
    step();
    check("ws_release", 32'(grant2), 32'h2);

    // INCR8 by mgr0 with mgr1 requesting throughout.
    rst2 = 1'b1; req2 = 2'b11; trans2 = T_IDLE; burst2 = B_SINGLE;
    step();
    rst2 = 1'b0;
    trans2 = T_NONSEQ; burst2 = B_INCR8;
    for (int b = 1; b <= 8; b++) begin
      step();
      check($sformatf("incr8_beat%0d", b), 32'(grant2), 32'(exp_full[b]));
      trans2 = T_SEQ;
    end

    // INCR8 terminated by IDLE after beat 3.
    rst2 = 1'b1; trans2 = T_IDLE; burst2 = B_SINGLE;
    step();
    rst2 = 1'b0;
    trans2 = T_NONSEQ; burst2 = B_INCR8;
    for (int b = 1; b <= 4; b++) begin
      step();
      check($sformatf("early_edge%0d", b), 32'(grant2), 32'(exp_early[b]));
      trans2 = (b < 3) ? T_SEQ : T_IDLE;
    end

    // Round-robin across four managers, owner 1, everyone requesting.
    step();
    rst4 = 1'b0;
    step();
    check("rr_setup_grant", 32'(grant4), 32'h2);
    step();
    check("rr_setup_hmaster", 32'(hm4), 32'h1);
    req4 = 4'b1111; trans4 = T_NONSEQ;
    for (int e = 1; e <= 11; e++) begin
      step();
      check($sformatf("rr_edge%0d", e), 32'(grant4), 32'(exp_rr[e]));
    end
    check("rr_final_hmaster", 32'(hm4), 32'h3);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
